seg_reader: RTL and testbench
=============================

Name: seg_reader

Overview:
- Reverse direction of the team's 7-segment decoder. Samples a multiplexed, active-high 7-segment display bus (segment pattern plus one-hot digit select) and recovers the BCD value of each digit.
- Each pattern must be stable for a programmable number of cycles before it is captured.
- When every digit position has been captured, the block presents a complete frame on a valid/ready output.
- Used for display loop-back checking and for reading legacy display-driven peripherals.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles {dig_sel, seg_in} must hold before capture; legal range 2..255.
- NDIG, 4: number of multiplexed digit positions; legal range 1..8.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment pattern, active-high; bit6=a, bit5=b … bit0=g.
- dig_sel  input  NDIG  one-hot digit select; bit i selects position i.
- frame_ready  input  1  consumer accepts frame when high with frame_valid.
- frame_valid  output  1  digits_out/blank_out/err_out hold a complete frame.
- digits_out  output  4*NDIG  position i in bits [4i+3:4i]; 0–9, 0xF blank, 0xE invalid.
- blank_out  output  NDIG  bit i set: position i was all segments off.
- err_out  output  NDIG  bit i set: position i held an undecodable pattern.
- overrun  output  1  sticky: a completed frame was dropped.
- bad_sel_cnt  output  8  saturating count of stable periods with non-one-hot dig_sel.

Behaviour:
- Reset (rst=1 at a clock edge) clears all outputs and internal state to 0: input register, run counter, slot registers, seen mask, frame_valid, overrun, bad_sel_cnt. Reset mid-frame discards partial captures.
- Input stage: {dig_sel, seg_in} is registered once (s_q).
- Run counter: 1 on the first cycle s_q takes a new value, +1 each cycle it is unchanged, saturating at STABLE_CYCLES.
- Capture strobe: asserts for exactly one cycle, when the run counter reaches STABLE_CYCLES. At most one capture per stable period. Changes shorter than STABLE_CYCLES cycles are ignored.
- Decode table, seg_in to value:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - 0000000→0xF with blank bit set
  - any other pattern→0xE with err bit set
- On capture with one-hot dig_sel bit i:
  - write slot i (value, blank, err) and set seen[i].
  - If seen[i] is already set, overwrite the slot (latest wins).
- On capture with dig_sel zero or multi-hot: bad_sel_cnt +1, saturating at 255. No slot or seen change.
- FSM with states COLLECT and FULL:
  - COLLECT: frame_valid=0. On the capture that makes seen all-ones, load the output registers from the slots (including the slot written that cycle), clear seen, go to FULL.
  - FULL: frame_valid=1. Outputs are held constant while frame_ready=0.
  - frame_valid && frame_ready: go to COLLECT, clear frame_valid next cycle, unless a frame completes in the same cycle. In that case load the new frame and stay in FULL; frame_valid stays 1.
  - A frame that completes in FULL without frame_ready=1 that cycle is dropped: seen is cleared, overrun is set, outputs are unchanged.
- Latency: the final digit's input, applied at cycle t and held, produces frame_valid=1 at cycle t+STABLE_CYCLES+1.
- overrun clears only on rst.

Test Plan:
- STABLE_CYCLES=4, NDIG=4, frame_ready=1. Drive (dig_sel, seg_in) = (0001, 0110000), (0010, 1101101), (0100, 1111001), (1000, 0110011), 6 cycles each → frame_valid pulses one cycle with digits_out=16'h4321, blank_out=0, err_out=0. frame_valid rises 5 cycles after the fourth pattern is applied.
- Glitch rejection: insert (0010, 1111111) held only 3 cycles between legal 6-cycle digits → ignored; frame is still 16'h4321.
- Invalid and blank: position 0 = 1000000, position 3 = 0000000 → digits_out=16'hF32E, err_out=0001, blank_out=1000.
- Backpressure: frame_ready=0 after frame 16'h4321; drive a second full frame 5,6,7,8 → frame 16'h4321 is held, overrun=1. Then frame_ready=1 for one cycle → frame_valid=0 and the next fresh frame is accepted normally.
- Bad select: dig_sel=0011 held 10 cycles → bad_sel_cnt=1, seen unchanged. 260 such periods → bad_sel_cnt=255.
- Reset mid-frame: capture positions 0 and 1, pulse rst one cycle, then drive positions 2 and 3 only → frame_valid stays 0. Driving all four positions afterwards produces a frame.

Source files
------------

// File: rtl/seg_reader_if.sv
// Display-bus sampling interface for seg_reader: the multiplexed segment/digit
// inputs, the frame valid/ready handshake and the status outputs.
interface seg_reader_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_sel;
    logic              frame_ready;
    logic              frame_valid;
    logic [4*NDIG-1:0] digits_out;
    logic [NDIG-1:0]   blank_out;
    logic [NDIG-1:0]   err_out;
    logic              overrun;
    logic [7:0]        bad_sel_cnt;

    // The display driver / frame consumer side
    modport master (
        output seg_in, dig_sel, frame_ready,
        input  frame_valid, digits_out, blank_out, err_out, overrun, bad_sel_cnt
    );

    // The seg_reader side
    modport slave (
        input  seg_in, dig_sel, frame_ready,
        output frame_valid, digits_out, blank_out, err_out, overrun, bad_sel_cnt
    );
endinterface

// File: rtl/seg_reader.sv
// seg_reader: samples a multiplexed active-high 7-segment bus, waits for each
// {dig_sel, seg_in} pattern to be stable for STABLE_CYCLES cycles, decodes it
// into a BCD slot and presents a complete NDIG-digit frame on valid/ready.
module seg_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int NDIG          = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg_reader_if.slave  bus
);
    localparam int              SW         = NDIG + 7;
    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [NDIG-1:0] ALL_SEEN   = {NDIG{1'b1}};
    localparam logic [NDIG-1:0] NONE_SEEN  = {NDIG{1'b0}};
    localparam logic [NDIG-1:0] ONE_SEL    = NDIG'(1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Returns {blank, err, value[3:0]} for a segment pattern (bit6=a .. bit0=g)
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode_seg = 6'b00_0000;
            7'b0110000: decode_seg = 6'b00_0001;
            7'b1101101: decode_seg = 6'b00_0010;
            7'b1111001: decode_seg = 6'b00_0011;
            7'b0110011: decode_seg = 6'b00_0100;
            7'b1011011: decode_seg = 6'b00_0101;
            7'b1011111: decode_seg = 6'b00_0110;
            7'b1110000: decode_seg = 6'b00_0111;
            7'b1111111: decode_seg = 6'b00_1000;
            7'b1111011: decode_seg = 6'b00_1001;
            7'b0000000: decode_seg = 6'b10_1111;
            default:    decode_seg = 6'b01_1110;
        endcase
    endfunction

    // True when exactly one digit-select bit is set
    function automatic logic is_one_hot(input logic [NDIG-1:0] sel);
        is_one_hot = (sel != NONE_SEEN) && ((sel & (sel - ONE_SEL)) == NONE_SEEN);
    endfunction

    logic [SW-1:0]     s_q;
    logic [SW-1:0]     in_s;
    logic [7:0]        run_cnt;
    logic [7:0]        run_next_s;
    logic              cap_r;
    logic              cap_next_s;

    logic [NDIG-1:0]   cap_sel_s;
    logic [5:0]        dec_s;
    logic              slot_wr_s;
    logic              complete_s;

    logic [4*NDIG-1:0] slot_digits_r, slot_digits_s;
    logic [NDIG-1:0]   slot_blank_r, slot_blank_s;
    logic [NDIG-1:0]   slot_err_r, slot_err_s;
    logic [NDIG-1:0]   seen_r, seen_s;

    state_t            state_r, state_s;
    logic              load_s;
    logic              drop_s;

    logic              frame_valid_r;
    logic [4*NDIG-1:0] digits_r;
    logic [NDIG-1:0]   blank_r;
    logic [NDIG-1:0]   err_r;
    logic              overrun_r;
    logic [7:0]        bad_cnt_r;

    // Stability run length of the registered input and the one-shot capture decision.
    // The counter stays at 0 after reset until the bus first differs from the cleared register.
    always_comb begin
        in_s       = {bus.dig_sel, bus.seg_in};
        run_next_s = run_cnt;
        if (in_s != s_q) begin
            run_next_s = 8'd1;
        end else if ((run_cnt == 8'd0) || (run_cnt == STABLE_MAX)) begin
            run_next_s = run_cnt;
        end else begin
            run_next_s = run_cnt + 8'd1;
        end
        cap_next_s = (run_next_s == STABLE_MAX) && (run_cnt != STABLE_MAX);
    end

    // Input register, run counter and capture strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= {SW{1'b0}};
            run_cnt <= 8'd0;
            cap_r   <= 1'b0;
        end else begin
            s_q     <= in_s;
            run_cnt <= run_next_s;
            cap_r   <= cap_next_s;
        end
    end

    // Decode the stable pattern and work out the slot / seen-mask updates
    always_comb begin
        cap_sel_s     = s_q[SW-1:7];
        dec_s         = decode_seg(s_q[6:0]);
        slot_wr_s     = cap_r && is_one_hot(cap_sel_s);
        slot_digits_s = slot_digits_r;
        slot_blank_s  = slot_blank_r;
        slot_err_s    = slot_err_r;
        seen_s        = seen_r;
        if (slot_wr_s) begin
            for (int i = 0; i < NDIG; i++) begin
                if (cap_sel_s[i]) begin
                    slot_digits_s[4*i +: 4] = dec_s[3:0];
                    slot_blank_s[i]         = dec_s[5];
                    slot_err_s[i]           = dec_s[4];
                end else begin
                    slot_digits_s[4*i +: 4] = slot_digits_r[4*i +: 4];
                    slot_blank_s[i]         = slot_blank_r[i];
                    slot_err_s[i]           = slot_err_r[i];
                end
            end
            seen_s = seen_r | cap_sel_s;
        end else begin
            seen_s = seen_r;
        end
        complete_s = slot_wr_s && (seen_s == ALL_SEEN);
    end

    // Slot registers and seen mask; the mask restarts whenever a frame completes
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_digits_r <= {(4*NDIG){1'b0}};
            slot_blank_r  <= NONE_SEEN;
            slot_err_r    <= NONE_SEEN;
            seen_r        <= NONE_SEEN;
        end else begin
            slot_digits_r <= slot_digits_s;
            slot_blank_r  <= slot_blank_s;
            slot_err_r    <= slot_err_s;
            seen_r        <= complete_s ? NONE_SEEN : seen_s;
        end
    end

    // Frame FSM next state: load a completed frame, drop it under backpressure
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        drop_s  = 1'b0;
        case (state_r)
            COLLECT: begin
                if (complete_s) begin
                    load_s  = 1'b1;
                    state_s = FULL;
                end else begin
                    state_s = COLLECT;
                end
            end
            FULL: begin
                if (complete_s) begin
                    if (bus.frame_ready) begin
                        load_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                    state_s = FULL;
                end else if (bus.frame_ready) begin
                    state_s = COLLECT;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = COLLECT;
            end
        endcase
    end

    // FSM state and registered frame outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= COLLECT;
            frame_valid_r <= 1'b0;
            digits_r      <= {(4*NDIG){1'b0}};
            blank_r       <= NONE_SEEN;
            err_r         <= NONE_SEEN;
            overrun_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            frame_valid_r <= (state_s == FULL);
            if (load_s) begin
                digits_r <= slot_digits_s;
                blank_r  <= slot_blank_s;
                err_r    <= slot_err_s;
            end
            overrun_r <= overrun_r | drop_s;
        end
    end

    // Saturating count of stable periods with a zero or multi-hot digit select
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_cnt_r <= 8'd0;
        end else if (cap_r && !is_one_hot(cap_sel_s) && (bad_cnt_r != 8'd255)) begin
            bad_cnt_r <= bad_cnt_r + 8'd1;
        end
    end

    assign bus.frame_valid = frame_valid_r;
    assign bus.digits_out  = digits_r;
    assign bus.blank_out   = blank_r;
    assign bus.err_out     = err_r;
    assign bus.overrun     = overrun_r;
    assign bus.bad_sel_cnt = bad_cnt_r;

endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: directed scenarios plus randomized bus
// traffic, every cycle compared against a frame-level reference model.
module tb_seg_reader;
    localparam int S = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_reader_if #(.NDIG(N)) bus();

    seg_reader #(.STABLE_CYCLES(S), .NDIG(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0]  m_slot_v [N];
    logic [N-1:0] m_slot_b, m_slot_e, m_seen;
    logic        m_full;
    logic [15:0] m_dig;
    logic [N-1:0] m_blank, m_err;
    logic        m_ovr;
    int          m_bad;
    logic [10:0] m_prev;
    int          m_cnt;
    logic        m_pend;
    logic [10:0] m_pend_val;

    // Observation bookkeeping
    int          cyc = 0;
    int          rise_cyc = 0;
    int          n_rise = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] last_dig;
    logic [3:0]  last_blank, last_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] seg, output logic [3:0] v,
                                       output logic b, output logic e);
        v = 4'hE; b = 1'b0; e = 1'b1;
        if (seg == 7'b0000000) begin
            v = 4'hF; b = 1'b1; e = 1'b0;
        end else begin
            for (int d = 0; d < 10; d++) begin
                if (pat[d] == seg) begin
                    v = 4'(d); e = 1'b0;
                end
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_slot_v[i] = 4'h0;
        m_slot_b = '0; m_slot_e = '0; m_seen = '0;
        m_full = 1'b0; m_dig = 16'h0; m_blank = '0; m_err = '0; m_ovr = 1'b0;
        m_bad = 0; m_prev = 11'h0; m_cnt = 0; m_pend = 1'b0; m_pend_val = 11'h0;
    endfunction

    // One clock edge of the reference model, using the inputs present at that edge
    function automatic void model_step();
        logic [3:0]  sel;
        logic [3:0]  v;
        logic        b, e, done, acc;
        logic [10:0] cur;
        if (rst) begin
            model_clear();
            return;
        end
        done = 1'b0;
        if (m_pend) begin
            sel = m_pend_val[10:7];
            if ($countones(sel) == 1) begin
                ref_decode(m_pend_val[6:0], v, b, e);
                for (int i = 0; i < N; i++) begin
                    if (sel[i]) begin
                        m_slot_v[i] = v; m_slot_b[i] = b; m_slot_e[i] = e;
                    end
                end
                m_seen = m_seen | sel;
                if (m_seen == 4'hF) done = 1'b1;
            end else if (m_bad < 255) begin
                m_bad++;
            end
        end
        acc = m_full && bus.frame_ready;
        if (done) begin
            m_seen = '0;
            if (!m_full || acc) begin
                for (int i = 0; i < N; i++) m_dig[4*i +: 4] = m_slot_v[i];
                m_blank = m_slot_b; m_err = m_slot_e; m_full = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (acc) begin
            m_full = 1'b0;
        end
        cur = {bus.dig_sel, bus.seg_in};
        m_pend = 1'b0;
        if (cur != m_prev) begin
            m_prev = cur; m_cnt = 1;
        end else if (m_cnt > 0 && m_cnt < S) begin
            m_cnt++;
            if (m_cnt == S) begin
                m_pend = 1'b1; m_pend_val = cur;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_val("frame_valid", 32'(bus.frame_valid), 32'(m_full));
        check_val("digits_out", 32'(bus.digits_out), 32'(m_dig));
        check_val("blank_out", 32'(bus.blank_out), 32'(m_blank));
        check_val("err_out", 32'(bus.err_out), 32'(m_err));
        check_val("overrun", 32'(bus.overrun), 32'(m_ovr));
        check_val("bad_sel_cnt", 32'(bus.bad_sel_cnt), 32'(m_bad));
        if (bus.frame_valid && !prev_valid) begin
            rise_cyc = cyc;
            n_rise++;
        end
        if (bus.frame_valid) begin
            last_dig = bus.digits_out; last_blank = bus.blank_out; last_err = bus.err_out;
        end
        prev_valid = bus.frame_valid;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        bus.dig_sel = sel;
        bus.seg_in  = seg;
        repeat (n) tick();
    endtask

    task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [6:0] p3);
        drive(4'b0001, p0, 6);
        drive(4'b0010, p1, 6);
        drive(4'b0100, p2, 6);
        drive(4'b1000, p3, 6);
    endtask

    initial begin
        int start;
        int r0;
        logic [3:0] sel;
        logic [6:0] seg;
        logic [31:0] rnd;

        model_clear();
        bus.seg_in = 7'h0; bus.dig_sel = 4'h0; bus.frame_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        check_val("rst_valid", 32'(bus.frame_valid), 32'd0);
        check_val("rst_digits", 32'(bus.digits_out), 32'd0);
        check_val("rst_overrun", 32'(bus.overrun), 32'd0);
        check_val("rst_bad", 32'(bus.bad_sel_cnt), 32'd0);
        rst = 1'b0;

        // Basic frame and latency
        drive(4'b0001, pat[1], 6);
        drive(4'b0010, pat[2], 6);
        drive(4'b0100, pat[3], 6);
        start = cyc;
        drive(4'b1000, pat[4], 6);
        check_val("f1_digits", 32'(last_dig), 32'h4321);
        check_val("f1_blank", 32'(last_blank), 32'h0);
        check_val("f1_err", 32'(last_err), 32'h0);
        check_val("f1_latency", 32'(rise_cyc - start), 32'd5);
        check_val("f1_pulse", 32'(bus.frame_valid), 32'd0);

        // Glitch rejection
        r0 = n_rise;
        drive(4'b0001, pat[1], 6);
        drive(4'b0010, 7'b1111111, 3);
        drive(4'b0010, pat[2], 6);
        drive(4'b0100, pat[3], 6);
        drive(4'b1000, pat[4], 6);
        check_val("glitch_frames", 32'(n_rise - r0), 32'd1);
        check_val("glitch_digits", 32'(last_dig), 32'h4321);

        // Invalid and blank positions
        frame4(7'b1000000, pat[2], pat[3], 7'b0000000);
        check_val("inv_digits", 32'(last_dig), 32'hF32E);
        check_val("inv_err", 32'(last_err), 32'h1);
        check_val("inv_blank", 32'(last_blank), 32'h8);

        // Backpressure and overrun
        bus.frame_ready = 1'b0;
        frame4(pat[1], pat[2], pat[3], pat[4]);
        frame4(pat[5], pat[6], pat[7], pat[8]);
        check_val("bp_valid", 32'(bus.frame_valid), 32'd1);
        check_val("bp_digits", 32'(bus.digits_out), 32'h4321);
        check_val("bp_overrun", 32'(bus.overrun), 32'd1);
        bus.frame_ready = 1'b1;
        tick();
        check_val("bp_release", 32'(bus.frame_valid), 32'd0);
        frame4(pat[9], pat[0], pat[1], pat[2]);
        check_val("bp_next", 32'(last_dig), 32'h2109);
        check_val("bp_sticky", 32'(bus.overrun), 32'd1);

        // Bad digit select, then saturation
        drive(4'b0011, 7'h01, 10);
        check_val("bad_one", 32'(bus.bad_sel_cnt), 32'd1);
        for (int i = 0; i < 259; i++) drive(4'b0011, (i % 2 == 0) ? 7'h02 : 7'h01, S);
        tick();
        check_val("bad_sat", 32'(bus.bad_sel_cnt), 32'd255);

        // Reset mid-frame discards partial captures
        drive(4'b0001, pat[1], 6);
        drive(4'b0010, pat[2], 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0 = n_rise;
        drive(4'b0100, pat[3], 6);
        drive(4'b1000, pat[4], 10);
        check_val("rstmid_none", 32'(n_rise - r0), 32'd0);
        check_val("rstmid_overrun", 32'(bus.overrun), 32'd0);
        frame4(pat[1], pat[2], pat[3], pat[4]);
        check_val("rstmid_frame", 32'(n_rise - r0), 32'd1);
        check_val("rstmid_digits", 32'(last_dig), 32'h4321);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 8) sel = 4'(1 << $urandom_range(0, 3));
            else sel = 4'($urandom_range(0, 15));
            rnd = $urandom;
            if ($urandom_range(0, 9) < 8) seg = pat[$urandom_range(0, 9)];
            else if ($urandom_range(0, 1) == 0) seg = 7'h00;
            else seg = rnd[6:0];
            bus.dig_sel = sel;
            bus.seg_in  = seg;
            rst = ($urandom_range(0, 99) == 0);
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
                bus.frame_ready = ($urandom_range(0, 3) != 0);
                tick();
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
